// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multicycle RISC-V main control FSM:
// state codes, opcode constants, ALUOp codes and the control vector.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_ALUWB    = 4'd7,
        S_EXECI    = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10,
        S_FAULT    = 4'd11
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    typedef struct packed {
        logic       pc_update;
        logic       branch;
        logic       ir_write;
        logic       reg_write;
        logic       mem_write;
        logic       adr_src;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       instr_done;
        logic       fault;
    } ctrl_t;

endpackage

// File: rtl/mc_ctrl_out_dec.sv
// Moore output decode: state -> control vector.
// Ports: state (in, current state), ctrl (out, control vector).
module mc_ctrl_out_dec
    import mc_ctrl_pkg::*;
(
    input  state_t state,
    output ctrl_t  ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.ir_write   = 1'b1;
                ctrl.alu_src_b  = 2'b10;
                ctrl.alu_op     = ALUOP_ADD;
                ctrl.result_src = 2'b10;
                ctrl.pc_update  = 1'b1;
            end
            S_DECODE: begin
                ctrl.alu_src_a = 2'b01;
                ctrl.alu_src_b = 2'b01;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEMADR: begin
                ctrl.alu_src_a = 2'b10;
                ctrl.alu_src_b = 2'b01;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEMREAD: begin
                ctrl.adr_src = 1'b1;
            end
            S_MEMWB: begin
                ctrl.result_src = 2'b01;
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_MEMWRITE: begin
                ctrl.adr_src    = 1'b1;
                ctrl.mem_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_EXECR: begin
                ctrl.alu_src_a = 2'b10;
                ctrl.alu_src_b = 2'b00;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_EXECI: begin
                ctrl.alu_src_a = 2'b10;
                ctrl.alu_src_b = 2'b01;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_BEQ: begin
                ctrl.alu_src_a  = 2'b10;
                ctrl.alu_op     = ALUOP_SUB;
                ctrl.branch     = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_JAL: begin
                ctrl.alu_src_a = 2'b01;
                ctrl.alu_src_b = 2'b10;
                ctrl.pc_update = 1'b1;
            end
            S_FAULT: begin
                ctrl.fault = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/mc_main_fsm.sv
// Multicycle RISC-V main control FSM (next-state logic, wait counter).
// Ports: CLK, RST (sync active-low), op, Zero, MemReady -> datapath
// enables/selects, InstrDone pulse, sticky Fault, debug State.
// Option: define MC_MEM_WAIT_EN to hold FETCH/MEMREAD/MEMWRITE until
// MemReady, with a WAIT_MAX-cycle timeout into FAULT.
module mc_main_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int WAIT_MAX = 15
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [6:0] op,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       AdrSrc,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic       InstrDone,
    output logic       Fault,
    output logic [3:0] State
);

    localparam logic [7:0] WAIT_LIM = 8'(WAIT_MAX);

    state_t state_q, state_d;
    ctrl_t  ctrl;

`ifdef MC_MEM_WAIT_EN
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] cnt_inc;
    logic       in_wait_state;
`else
    logic [8:0] mem_unused;
    assign mem_unused = {MemReady, WAIT_LIM};
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                unique case (1'b1)
                    (op == OP_LW) || (op == OP_SW): state_d = S_MEMADR;
                    op == OP_R:   state_d = S_EXECR;
                    op == OP_I:   state_d = S_EXECI;
                    op == OP_BEQ: state_d = S_BEQ;
                    op == OP_JAL: state_d = S_JAL;
                    default:      state_d = S_FAULT;
                endcase
            end
            // op is re-sampled here to choose the access direction
            S_MEMADR:   state_d = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  state_d = S_MEMWB;
            S_EXECR,
            S_EXECI,
            S_JAL:      state_d = S_ALUWB;
            S_MEMWB,
            S_MEMWRITE,
            S_ALUWB,
            S_BEQ:      state_d = S_FETCH;
            S_FAULT:    state_d = S_FAULT;
            default:    state_d = S_FAULT;
        endcase

`ifdef MC_MEM_WAIT_EN
        // Counter clears on MemReady or any state change; a hold that
        // would bring it to WAIT_MAX times out into FAULT instead.
        cnt_d         = '0;
        cnt_inc       = cnt_q + 8'd1;
        in_wait_state = (state_q == S_FETCH) ||
                        (state_q == S_MEMREAD) ||
                        (state_q == S_MEMWRITE);
        if (in_wait_state && !MemReady) begin
            if (cnt_inc >= WAIT_LIM) begin
                state_d = S_FAULT;
            end else begin
                state_d = state_q;
                cnt_d   = cnt_inc;
            end
        end
`endif
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q <= S_FETCH;
`ifdef MC_MEM_WAIT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
`ifdef MC_MEM_WAIT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    mc_ctrl_out_dec u_dec (
        .state (state_q),
        .ctrl  (ctrl)
    );

    assign PCWrite   = ctrl.pc_update | (ctrl.branch & Zero);
    assign IRWrite   = ctrl.ir_write;
    assign RegWrite  = ctrl.reg_write;
    assign MemWrite  = ctrl.mem_write;
    assign AdrSrc    = ctrl.adr_src;
    assign ResultSrc = ctrl.result_src;
    assign ALUSrcA   = ctrl.alu_src_a;
    assign ALUSrcB   = ctrl.alu_src_b;
    assign ALUOp     = ctrl.alu_op;
    assign Fault     = ctrl.fault;
    assign State     = state_q;

`ifdef MC_MEM_WAIT_EN
    // A store only completes once memory accepts it.
    assign InstrDone = ctrl.instr_done &
                       ((state_q != S_MEMWRITE) | MemReady);
`else
    assign InstrDone = ctrl.instr_done;
`endif

endmodule

// File: doc/mc_main_fsm.md
MC_MAIN_FSM -- requirements
Module: mc_main_fsm

Interface
REQ-001 Parameter WAIT_MAX, default 15, max cycles one memory access may wait before a fault (range 1..255).
REQ-002 CLK  in  1  sole clock; all state updates on rising edge.
REQ-003 RST  in  1  reset; synchronous and active-low.
REQ-004 op  in  7  opcode field of the instruction register.
REQ-005 Zero  in  1  ALU zero flag.
REQ-006 MemReady  in  1  memory access-complete handshake; used only with MC_MEM_WAIT_EN.
REQ-007 PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc  out  1 each  datapath enables/selects.
REQ-008 ResultSrc, ALUSrcA, ALUSrcB, ALUOp  out  2 each  mux selects; ALUOp drives the ALU decoder.
REQ-009 InstrDone  out  1  one-cycle pulse in the final state of each instruction.
REQ-010 Fault  out  1  sticky error flag.
REQ-011 State  out  4  current state encoding, for debug.

Function
REQ-012 The state encoding SHALL be FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, ALUWB=7, EXECI=8, JAL=9, BEQ=10, FAULT=11; codes 12-15 SHALL go to FAULT on the next edge.
REQ-013 Transitions:
- FETCH->DECODE.
- DECODE branches on op:
  - lw 0000011 / sw 0100011 -> MEMADR.
  - R 0110011 -> EXECR.
  - I 0010011 -> EXECI.
  - beq 1100011 -> BEQ.
  - jal 1101111 -> JAL.
  - any other op -> FAULT.
REQ-014 Transitions:
- MEMADR->MEMREAD for lw, MEMWRITE for sw, using op sampled in MEMADR.
- MEMREAD->MEMWB.
- EXECR, EXECI, JAL->ALUWB.
- MEMWB, MEMWRITE, ALUWB, BEQ->FETCH.
- FAULT->FAULT until reset.
REQ-015 Outputs SHALL be Moore, decoded from State only (PCWrite excepted); any signal not listed below is 0.
- FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, PCUpdate=1.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00.
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00.
- MEMREAD: AdrSrc=1, ResultSrc=00.
- MEMWB: ResultSrc=01, RegWrite=1.
- MEMWRITE: AdrSrc=1, MemWrite=1.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10.
- EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10.
- ALUWB: ResultSrc=00, RegWrite=1.
- BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1.
- FAULT: all 0.
REQ-016 PCWrite SHALL equal PCUpdate OR (Branch AND Zero), combinational in the same cycle.
REQ-017 InstrDone SHALL be 1 exactly in MEMWB, MEMWRITE, ALUWB and BEQ, and gated by a completed access where MC_MEM_WAIT_EN applies.
REQ-018 Fault SHALL be 1 whenever State==FAULT.
REQ-019 Instruction latencies without MC_MEM_WAIT_EN:
- lw 5 cycles.
- sw 4 cycles.
- R-type 4 cycles.
- I-type 4 cycles.
- jal 4 cycles.
- beq 3 cycles.

Reset
REQ-020 With RST=0 at a rising edge, State SHALL become FETCH and the wait counter 0, overriding any in-flight state including FAULT and mid-wait.
REQ-021 During and after reset, outputs SHALL equal FETCH decode and Fault=0.
REQ-022 MemReady and op SHALL be ignored while RST=0.

Configuration
REQ-023 Macro MC_MEM_WAIT_EN, when defined, SHALL hold FETCH, MEMREAD and MEMWRITE until MemReady=1.
REQ-024 While held:
- IRWrite, PCUpdate and MemWrite SHALL stay asserted.
- An 8-bit wait counter SHALL increment each cycle.
- The counter SHALL clear on MemReady=1 or on a state change.
REQ-025 If the counter reaches WAIT_MAX with MemReady=0, the FSM SHALL enter FAULT next edge.
REQ-026 MemReady=1 on the first cycle of a wait state SHALL give zero added latency.
REQ-027 Without MC_MEM_WAIT_EN:
- MemReady SHALL be unused.
- No counter SHALL exist.
- WAIT_MAX SHALL have no effect.
- Every state SHALL last one cycle.

Structure
REQ-028 Shared package mc_ctrl_pkg SHALL hold the state codes, the opcode constants and the ALUOp codes (00 add, 01 sub, 10 funct-decoded).
REQ-029 Output decode SHALL be one sub-module, mc_ctrl_out_dec (State -> control vector); the next-state logic and counter stay in mc_main_fsm.

Verification
REQ-030 Reset, then lw op=0000011:
- State sequence 0,1,2,3,4,0.
- RegWrite=1 only in state 4.
- InstrDone pulses once.
REQ-031 sw op=0100011:
- State sequence 0,1,2,5,0.
- MemWrite=1 for exactly one cycle, with AdrSrc=1.
REQ-032 beq op=1100011:
- With Zero=1 in BEQ, PCWrite=1.
- With Zero=0 in BEQ, PCWrite=0.
- ALUOp=01 in BEQ in both cases.
REQ-033 op=1111111 in DECODE:
- FAULT, Fault=1, held for 20 cycles.
- RST=0 for one edge returns State to 0.
REQ-034 MC_MEM_WAIT_EN, WAIT_MAX=4, MemReady=0 in MEMREAD:
- FAULT after 4 wait cycles.
- MemReady=1 on wait cycle 2 instead reaches MEMWB.
REQ-035 RST asserted in EXECR: next State=0, RegWrite never asserted for the aborted instruction.
